maxpool2x2_reader: RTL and testbench

- Downstream consumer of the feature-map BRAM.
- After a CONV stage has written a feature map, the FSM pulses start. This block then:
  - sequences BRAM read addresses,
  - absorbs the BRAM's 1-cycle synchronous read latency,
  - computes a 2x2 stride-2 signed max-pool,
  - streams pooled values out with a valid/ready handshake.
- It only reads. It never drives the BRAM write enable; the top-level FSM holds we low while this block is busy.

---
 rtl/maxpool2x2_reader.sv | 170 +++++++++++++++++
 tb/tb_maxpool2x2_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/maxpool2x2_reader.sv
// maxpool2x2_reader: walks a row-major feature map held in a synchronous-read
// BRAM, takes the signed maximum of each 2x2 stride-2 window, and streams the
// pooled values out over a valid/ready handshake. The block only reads the BRAM.
// Optional build macro: MAXPOOL_RELU_EN (clamps negative maxima to zero at the
// output register; timing and handshake unchanged).
module maxpool2x2_reader #(
  parameter int IN_H      = 16,
  parameter int IN_W      = 16,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 2048,
  parameter int BASE_ADDR = 0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [$clog2(DEPTH)-1:0]   bram_addr_o,
  input  logic signed [WIDTH-1:0]    bram_rdata_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic signed [WIDTH-1:0]    out_data_o,
  output logic                       out_last_o
);

  localparam int AW       = $clog2(DEPTH);
  localparam int OUT_H    = IN_H / 2;
  localparam int OUT_W    = IN_W / 2;
  localparam int RW       = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam int CW       = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(OUT_H - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(OUT_W - 1);
  localparam logic [AW-1:0] BASE     = AW'(BASE_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    FIN   = 3'd4
  } state_t;

  state_t                   state_q;
  logic [1:0]               k_q;
  logic [RW-1:0]            orow_q;
  logic [CW-1:0]            ocol_q;
  logic signed [WIDTH-1:0]  max_q;
  logic signed [WIDTH-1:0]  out_data_q;
  logic [AW-1:0]            addr_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     out_valid_q;
  logic                     out_last_q;

  logic signed [WIDTH-1:0]  max_d;
  logic signed [WIDTH-1:0]  out_data_d;
  logic [RW-1:0]            orow_d;
  logic [CW-1:0]            ocol_d;
  logic                     at_last;
  logic                     first_cap;

  // Address of element k (0=TL,1=TR,2=BL,3=BR) of pooled window (r,c).
  function automatic logic [AW-1:0] win_addr(input int r, input int c, input int kk);
    int a;
    a = BASE_ADDR + (2 * r + kk / 2) * IN_W + 2 * c + kk % 2;
    return AW'(a);
  endfunction

  // Running-max update, window position bookkeeping and output clamp.
  always_comb begin
    first_cap = (state_q == ISSUE) && (k_q == 2'd1);
    max_d     = max_q;
    if (first_cap || (bram_rdata_i > max_q))
      max_d = bram_rdata_i;
`ifdef MAXPOOL_RELU_EN
    out_data_d = (max_d < 0) ? '0 : max_d;
`else
    out_data_d = max_d;
`endif
    at_last = (orow_q == LAST_ROW) && (ocol_q == LAST_COL);
    orow_d  = orow_q;
    ocol_d  = ocol_q + CW'(1);
    if (ocol_q == LAST_COL) begin
      ocol_d = '0;
      orow_d = orow_q + RW'(1);
    end
  end

  // Pass sequencer: address issue, capture, emit and completion, all registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      k_q         <= '0;
      orow_q      <= '0;
      ocol_q      <= '0;
      max_q       <= '0;
      out_data_q  <= '0;
      addr_q      <= BASE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          addr_q <= BASE;
          if (start_i) begin
            orow_q  <= '0;
            ocol_q  <= '0;
            k_q     <= '0;
            busy_q  <= 1'b1;
            addr_q  <= win_addr(0, 0, 0);
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          // Data for address k-1 arrives while address k is presented.
          if (k_q != 2'd0)
            max_q <= max_d;
          if (k_q == 2'd3) begin
            state_q <= DRAIN;
          end else begin
            k_q    <= k_q + 2'd1;
            addr_q <= win_addr(int'(orow_q), int'(ocol_q), int'(k_q) + 1);
          end
        end
        DRAIN: begin
          max_q       <= max_d;
          out_data_q  <= out_data_d;
          out_last_q  <= at_last;
          out_valid_q <= 1'b1;
          state_q     <= EMIT;
        end
        EMIT: begin
          if (out_valid_q && out_ready_i) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            if (at_last) begin
              done_q  <= 1'b1;
              state_q <= FIN;
            end else begin
              orow_q  <= orow_d;
              ocol_q  <= ocol_d;
              k_q     <= '0;
              addr_q  <= win_addr(int'(orow_d), int'(ocol_d), 0);
              state_q <= ISSUE;
            end
          end
        end
        FIN: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          addr_q  <= BASE;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign bram_addr_o = addr_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_maxpool2x2_reader.sv
// Directed bench for maxpool2x2_reader on a 4x4 map with a behavioural
// 1-cycle-latency BRAM.
module tb_maxpool2x2_reader;

  localparam int IN_H = 4;
  localparam int IN_W = 4;
  localparam int WIDTH = 16;
  localparam int DEPTH = 2048;
  localparam int AW = 11;

`ifdef MAXPOOL_RELU_EN
  localparam logic signed [15:0] EXP_NEG3 = 16'sd0;
  localparam logic signed [15:0] EXP_M5   = 16'sd0;
`else
  localparam logic signed [15:0] EXP_NEG3 = -16'sd3;
  localparam logic signed [15:0] EXP_M5   = -16'sd5;
`endif

  logic clk = 1'b0;
  logic rst, start, busy, done, out_valid, out_ready, out_last;
  logic [AW-1:0] bram_addr;
  logic signed [WIDTH-1:0] bram_rdata, out_data;
  logic signed [WIDTH-1:0] mem [0:DEPTH-1];

  int checks = 0;
  int errors = 0;

  // Observation record filled by collect()
  logic signed [15:0] obs_data [0:7];
  logic obs_last [0:7];
  int obs_n, done_n, first_v, last_hs, done_c;
  logic busy_post;

  always #5 clk = ~clk;

  always @(posedge clk) bram_rdata <= mem[bram_addr];

  maxpool2x2_reader #(
    .IN_H(IN_H), .IN_W(IN_W), .WIDTH(WIDTH), .DEPTH(DEPTH), .BASE_ADDR(0)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .bram_addr_o(bram_addr), .bram_rdata_i(bram_rdata),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_last_o(out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < DEPTH; i++) mem[i] = 16'(i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Observe ncyc cycles; c0 is the cycle index of the first sample.
  task automatic collect(input int c0, input int ncyc);
    obs_n = 0; done_n = 0; first_v = -1; last_hs = -1; done_c = -1; busy_post = 1'b1;
    for (int c = c0; c < c0 + ncyc; c++) begin
      if (out_valid && first_v < 0) first_v = c;
      if (out_valid && out_ready) begin
        if (obs_n < 8) begin
          obs_data[obs_n] = out_data;
          obs_last[obs_n] = out_last;
        end
        obs_n++;
        last_hs = c;
      end
      if (done) begin
        done_n++;
        done_c = c;
      end
      if (done_c >= 0 && c == done_c + 1) busy_post = busy;
      tick();
    end
  endtask

  task automatic wait_valid(input string nm);
    int n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting out_valid got %b want 1", nm, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    checks++;
    if ({busy, done, out_valid, out_last} !== 4'b0000 || out_data !== 16'sd0 || bram_addr !== 11'd0) begin
      errors++;
      $display("FAIL reset got busy=%b done=%b v=%b last=%b data=%0d addr=%0d want 0s",
               busy, done, out_valid, out_last, out_data, bram_addr);
    end
  endtask

  task automatic test_basic();
    logic signed [15:0] exp_v [0:3];
    exp_v[0] = 16'sd5; exp_v[1] = 16'sd7; exp_v[2] = 16'sd13; exp_v[3] = 16'sd15;
    fill_ramp();
    pulse_start();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy got %b want 1", busy);
    end
    collect(1, 40);
    checks++;
    if (first_v !== 6) begin
      errors++;
      $display("FAIL basic_latency got %0d want 6", first_v);
    end
    checks++;
    if (obs_n !== 4) begin
      errors++;
      $display("FAIL basic_count got %0d want 4", obs_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_data[i] !== exp_v[i] || obs_last[i] !== (i == 3)) begin
        errors++;
        $display("FAIL basic_out%0d got %0d last=%b want %0d last=%b",
                 i, obs_data[i], obs_last[i], exp_v[i], (i == 3));
      end
    end
    checks++;
    if (done_n !== 1 || done_c !== last_hs + 1) begin
      errors++;
      $display("FAIL basic_done got n=%0d at %0d want 1 at %0d", done_n, done_c, last_hs + 1);
    end
    checks++;
    if (busy_post !== 1'b0 || bram_addr !== 11'd0) begin
      errors++;
      $display("FAIL basic_idle got busy=%b addr=%0d want 0 0", busy_post, bram_addr);
    end
  endtask

  task automatic test_all_neg();
    for (int i = 0; i < 16; i++) mem[i] = -16'sd3;
    pulse_start();
    collect(1, 40);
    checks++;
    if (obs_n !== 4 || done_n !== 1) begin
      errors++;
      $display("FAIL neg_count got n=%0d done=%0d want 4 1", obs_n, done_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_data[i] !== EXP_NEG3) begin
        errors++;
        $display("FAIL neg_out%0d got %0d want %0d", i, obs_data[i], EXP_NEG3);
      end
    end
  endtask

  task automatic test_signed();
    logic signed [15:0] exp_v [0:3];
    mem[0]  = -16'sd7;     mem[1]  = 16'sd2;   mem[4]  = -16'sd1;  mem[5]  = -16'sd32768;
    mem[2]  = -16'sd32768; mem[3]  = -16'sd5;  mem[6]  = -16'sd9;  mem[7]  = -16'sd6;
    mem[8]  = 16'sd100;    mem[9]  = -16'sd1;  mem[12] = -16'sd2;  mem[13] = -16'sd3;
    mem[10] = -16'sd3;     mem[11] = -16'sd3;  mem[14] = -16'sd3;  mem[15] = 16'sd50;
    exp_v[0] = 16'sd2; exp_v[1] = EXP_M5; exp_v[2] = 16'sd100; exp_v[3] = 16'sd50;
    pulse_start();
    collect(1, 40);
    checks++;
    if (obs_n !== 4) begin
      errors++;
      $display("FAIL signed_count got %0d want 4", obs_n);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_data[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL signed_out%0d got %0d want %0d", i, obs_data[i], exp_v[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [AW-1:0] a0;
    fill_ramp();
    pulse_start();
    wait_valid("stall_wait");
    out_ready = 1'b0;
    a0 = bram_addr;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'sd5 || bram_addr !== a0) begin
        errors++;
        $display("FAIL stall_hold%0d got v=%b data=%0d addr=%0d want 1 5 %0d",
                 i, out_valid, out_data, bram_addr, a0);
      end
    end
    out_ready = 1'b1;
    collect(0, 40);
    checks++;
    if (obs_n !== 4 || done_n !== 1 || obs_data[0] !== 16'sd5 || obs_data[1] !== 16'sd7 ||
        obs_data[2] !== 16'sd13 || obs_data[3] !== 16'sd15) begin
      errors++;
      $display("FAIL stall_seq got n=%0d done=%0d %0d %0d %0d %0d want 4 1 5 7 13 15",
               obs_n, done_n, obs_data[0], obs_data[1], obs_data[2], obs_data[3]);
    end
  endtask

  task automatic test_start_ignored();
    pulse_start();
    wait_valid("ign_wait");
    tick();            // first handshake happens on this edge
    tick();            // now in ISSUE of the second window
    pulse_start();
    collect(0, 40);
    checks++;
    if (obs_n !== 3 || done_n !== 1 || obs_data[0] !== 16'sd7 || obs_data[2] !== 16'sd15) begin
      errors++;
      $display("FAIL ignore_start got n=%0d done=%0d first=%0d last=%0d want 3 1 7 15",
               obs_n, done_n, obs_data[0], obs_data[2]);
    end
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle got busy=%b v=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_rst_mid();
    pulse_start();
    wait_valid("rst_wait1");
    tick();
    wait_valid("rst_wait2");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || bram_addr !== 11'd0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got busy=%b v=%b addr=%0d done=%b want 0 0 0 0",
               busy, out_valid, bram_addr, done);
    end
    collect(0, 10);
    checks++;
    if (done_n !== 0 || obs_n !== 0) begin
      errors++;
      $display("FAIL rst_quiet got done=%0d outs=%0d want 0 0", done_n, obs_n);
    end
    pulse_start();
    collect(1, 40);
    checks++;
    if (obs_n !== 4 || done_n !== 1 || obs_data[0] !== 16'sd5 || obs_data[1] !== 16'sd7 ||
        obs_data[2] !== 16'sd13 || obs_data[3] !== 16'sd15 || obs_last[3] !== 1'b1) begin
      errors++;
      $display("FAIL rst_restart got n=%0d done=%0d %0d %0d %0d %0d want 4 1 5 7 13 15",
               obs_n, done_n, obs_data[0], obs_data[1], obs_data[2], obs_data[3]);
    end
  endtask

  initial begin
    fill_ramp();
    test_reset();
    test_basic();
    test_all_neg();
    test_signed();
    test_stall();
    test_start_ignored();
    test_rst_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
